// File: rtl/lsu_mem_ctrl.sv
// ---------------------------------------------------------------------------
// lsu_mem_ctrl
//   Load/store initiator for a word-wide data memory without byte enables.
//   One request is taken at a time over a valid/ready handshake. Sub-word
//   stores use a read-modify-write: the word is read, the addressed lanes
//   are replaced, and the merged word is written back. Loads return
//   sign- or zero-extended data. Each request ends with a one-cycle
//   resp_valid pulse carrying data or an error code.
//
// Ports
//   clk, rst           clock, synchronous active-high reset
//   req_valid/ready    request handshake (ready only when idle)
//   req_is_store       1 = store, 0 = load
//   req_funct3         RV32I funct3 (size / sign)
//   req_addr           byte address
//   req_wdata          store data (low bytes used for SB/SH)
//   resp_valid         one-cycle completion pulse
//   resp_rdata         extended load data, 0 for stores and errors
//   resp_err           00 ok, 01 misaligned, 10 out of range, 11 bad funct3
//   mem_read/write     memory strobes (never both high, low during rst)
//   mem_address        word index {2'b0, addr[31:2]}
//   mem_write_data     word to write
//   mem_read_data      combinational memory read data
// ---------------------------------------------------------------------------
module lsu_mem_ctrl #(
    parameter int MEM_WORDS = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_is_store,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic [1:0]  resp_err,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_address,
    output logic [31:0] mem_write_data,
    input  logic [31:0] mem_read_data
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD   = 3'd1,
        S_WR   = 3'd2,
        S_RESP = 3'd3,
        S_ERR  = 3'd4
    } state_t;

    localparam logic [1:0] ERR_NONE  = 2'b00;
    localparam logic [1:0] ERR_ALIGN = 2'b01;
    localparam logic [1:0] ERR_RANGE = 2'b10;
    localparam logic [1:0] ERR_F3    = 2'b11;

    state_t      state, state_nxt;
    logic        accept;
    logic [1:0]  err_chk;

    // Request fields are data only; they are qualified by the state, so
    // they carry no reset.
    logic        is_store_q;
    logic [2:0]  funct3_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] word_q;
    logic [1:0]  err_q;

    // Priority: illegal funct3 > misaligned > out of range.
    function automatic logic [1:0] check_err(input logic        is_store,
                                             input logic [2:0]  f3,
                                             input logic [31:0] addr);
        logic illegal;
        logic misaligned;
        logic range_bad;
        if (is_store)
            illegal = (f3 > 3'b010);
        else
            illegal = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
        misaligned = ((f3[1:0] == 2'b01) && addr[0]) ||
                     ((f3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
        range_bad  = ({2'b00, addr[31:2]} >= 32'(MEM_WORDS));
        if (illegal)
            return ERR_F3;
        else if (misaligned)
            return ERR_ALIGN;
        else if (range_bad)
            return ERR_RANGE;
        else
            return ERR_NONE;
    endfunction

    // Shift the addressed lanes down to bit 0, then extend by funct3.
    function automatic logic [31:0] load_extract(input logic [2:0]  f3,
                                                 input logic [1:0]  lane,
                                                 input logic [31:0] word);
        logic [31:0]        shifted;
        logic signed [7:0]  byte_s;
        logic signed [15:0] half_s;
        shifted = word >> {lane, 3'b000};
        byte_s  = shifted[7:0];
        half_s  = shifted[15:0];
        case (f3)
            3'b000:  return 32'(byte_s);
            3'b001:  return 32'(half_s);
            3'b010:  return word;
            3'b100:  return {24'h0, shifted[7:0]};
            3'b101:  return {16'h0, shifted[15:0]};
            default: return 32'h0;
        endcase
    endfunction

    // Replace the addressed lanes of the captured word with store data.
    function automatic logic [31:0] store_merge(input logic [2:0]  f3,
                                                input logic [1:0]  lane,
                                                input logic [31:0] word,
                                                input logic [31:0] wdata);
        logic [31:0] merged;
        merged = word;
        case (f3)
            3'b000:  merged[{lane, 3'b000} +: 8]      = wdata[7:0];
            3'b001:  merged[{lane[1], 4'b0000} +: 16] = wdata[15:0];
            default: merged = wdata;
        endcase
        return merged;
    endfunction

    assign accept  = req_valid && (state == S_IDLE);
    assign err_chk = check_err(req_is_store, req_funct3, req_addr);

    // State register
    always_ff @(posedge clk) begin
        if (rst)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    // Request capture and read-data capture
    always_ff @(posedge clk) begin
        if (accept) begin
            is_store_q <= req_is_store;
            funct3_q   <= req_funct3;
            addr_q     <= req_addr;
            wdata_q    <= req_wdata;
            err_q      <= err_chk;
        end
        if (state == S_RD)
            word_q <= mem_read_data;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (req_valid) begin
                    if (err_chk != ERR_NONE)
                        state_nxt = S_ERR;
                    else if (req_is_store && (req_funct3 == 3'b010))
                        state_nxt = S_WR;
                    else
                        state_nxt = S_RD;
                end
            end
            S_RD:    state_nxt = is_store_q ? S_WR : S_RESP;
            S_WR:    state_nxt = S_RESP;
            S_RESP:  state_nxt = S_IDLE;
            S_ERR:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Outputs; strobes are masked by rst so a reset in RD/WR never
    // produces a partial write.
    always_comb begin
        req_ready      = 1'b0;
        resp_valid     = 1'b0;
        resp_rdata     = 32'h0;
        resp_err       = ERR_NONE;
        mem_read       = 1'b0;
        mem_write      = 1'b0;
        mem_address    = 32'h0;
        mem_write_data = 32'h0;
        case (state)
            S_IDLE: req_ready = 1'b1;
            S_RD: begin
                mem_read    = !rst;
                mem_address = {2'b00, addr_q[31:2]};
            end
            S_WR: begin
                mem_write      = !rst;
                mem_address    = {2'b00, addr_q[31:2]};
                mem_write_data = store_merge(funct3_q, addr_q[1:0], word_q, wdata_q);
            end
            S_RESP: begin
                resp_valid = 1'b1;
                resp_rdata = is_store_q ? 32'h0
                                        : load_extract(funct3_q, addr_q[1:0], word_q);
            end
            S_ERR: begin
                resp_valid = 1'b1;
                resp_err   = err_q;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
module tb_lsu_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_is_store = 1'b0;
    logic [2:0]  req_funct3 = 3'b0;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic [1:0]  resp_err;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_address;
    logic [31:0] mem_write_data;
    logic [31:0] mem_read_data;

    always #5 clk = ~clk;

    lsu_mem_ctrl #(.MEM_WORDS(32)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_is_store(req_is_store), .req_funct3(req_funct3),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_read(mem_read), .mem_write(mem_write),
        .mem_address(mem_address), .mem_write_data(mem_write_data),
        .mem_read_data(mem_read_data)
    );

    // Data memory model: combinational read, posedge write
    logic [31:0] mem [32];
    assign mem_read_data = (mem_address < 32'd32) ? mem[mem_address[4:0]] : 32'h0;
    always @(posedge clk)
        if (mem_write && (mem_address < 32'd32))
            mem[mem_address[4:0]] <= mem_write_data;

    int checks = 0;
    int failures = 0;
    int rd_cycles = 0;
    int wr_cycles = 0;

    typedef struct {
        logic [31:0] rdata;
        logic [1:0]  err;
    } exp_t;
    exp_t exp_q[$];

    typedef struct {
        logic        st;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic [1:0]  err;
        int          lat;
        int          rd;
        int          wr;
    } vec_t;
    vec_t vecs [24];
    int   nvec = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
        end
    endtask

    // Scoreboard monitor and strobe accounting
    always @(negedge clk) begin
        if (!rst) begin
            if (mem_read) rd_cycles++;
            if (mem_write) wr_cycles++;
            if (mem_read && mem_write) begin
                checks++;
                failures++;
                $display("FAIL strobes: mem_read and mem_write both high");
            end
            if (resp_valid) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL resp_unexpected: rdata 0x%08h err %0d with nothing outstanding",
                             resp_rdata, resp_err);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    if (resp_rdata !== e.rdata || resp_err !== e.err) begin
                        failures++;
                        $display("FAIL resp: got rdata 0x%08h err %0d expected rdata 0x%08h err %0d",
                                 resp_rdata, resp_err, e.rdata, e.err);
                    end
                end
            end
        end
    end

    function automatic vec_t mk(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [31:0] rdata,
                                input logic [1:0] err, input int lat, input int rd, input int wr);
        vec_t v;
        v.st = st; v.f3 = f3; v.addr = addr; v.wdata = wdata; v.rdata = rdata;
        v.err = err; v.lat = lat; v.rd = rd; v.wr = wr;
        return v;
    endfunction

    task automatic add(input vec_t v);
        vecs[nvec] = v;
        nvec++;
    endtask

    // Issue one request, push its expectation, and measure latency in edges
    // counted from (and including) the acceptance edge.
    task automatic run_vec(input vec_t v, input int idx);
        int   edges;
        int   waitc;
        exp_t e;
        string nm;
        @(negedge clk);
        waitc = 0;
        while (!req_ready && waitc < 50) begin
            @(negedge clk);
            waitc++;
        end
        rd_cycles = 0;
        wr_cycles = 0;
        req_valid = 1'b1; req_is_store = v.st; req_funct3 = v.f3;
        req_addr = v.addr; req_wdata = v.wdata;
        e.rdata = v.rdata; e.err = v.err;
        exp_q.push_back(e);
        @(posedge clk);
        edges = 1;
        @(negedge clk);
        req_valid = 1'b0;
        while (!resp_valid && edges < 20) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
        end
        nm = $sformatf("lat[%0d]", idx);
        check(nm, 32'(edges), 32'(v.lat));
        nm = $sformatf("rd_cycles[%0d]", idx);
        check(nm, 32'(rd_cycles), 32'(v.rd));
        nm = $sformatf("wr_cycles[%0d]", idx);
        check(nm, 32'(wr_cycles), 32'(v.wr));
    endtask

    initial begin
        int edges;
        exp_t e;
        for (int i = 0; i < 32; i++) mem[i] = 32'h0101_0101 * i;
        mem[0] = 32'h0123_4567;
        mem[1] = 32'h7654_3210;
        mem[3] = 32'h8899_AABB;
        mem[5] = 32'h5566_7788;
        mem[31] = 32'hCAFE_F00D;

        // st f3 addr wdata rdata err lat rd wr
        add(mk(0, 3'b000, 32'h0D, 32'h0,          32'hFFFF_FFAA, 2'b00, 2, 1, 0)); // LB
        add(mk(0, 3'b100, 32'h0D, 32'h0,          32'h0000_00AA, 2'b00, 2, 1, 0)); // LBU
        add(mk(0, 3'b010, 32'h0C, 32'h0,          32'h8899_AABB, 2'b00, 2, 1, 0)); // LW
        add(mk(0, 3'b001, 32'h0E, 32'h0,          32'hFFFF_8899, 2'b00, 2, 1, 0)); // LH upper
        add(mk(0, 3'b101, 32'h0E, 32'h0,          32'h0000_8899, 2'b00, 2, 1, 0)); // LHU upper
        add(mk(0, 3'b000, 32'h0C, 32'h0,          32'hFFFF_FFBB, 2'b00, 2, 1, 0)); // LB lane0
        add(mk(0, 3'b100, 32'h0F, 32'h0,          32'h0000_0088, 2'b00, 2, 1, 0)); // LBU lane3
        add(mk(1, 3'b000, 32'h0E, 32'h1122_3344,  32'h0,         2'b00, 3, 1, 1)); // SB
        add(mk(0, 3'b010, 32'h0C, 32'h0,          32'h8844_AABB, 2'b00, 2, 1, 0)); // LW after SB
        add(mk(1, 3'b010, 32'h10, 32'hDEAD_BEEF,  32'h0,         2'b00, 2, 0, 1)); // SW
        add(mk(0, 3'b001, 32'h12, 32'h0,          32'hFFFF_DEAD, 2'b00, 2, 1, 0)); // LH
        add(mk(0, 3'b101, 32'h10, 32'h0,          32'h0000_BEEF, 2'b00, 2, 1, 0)); // LHU
        add(mk(0, 3'b000, 32'h11, 32'h0,          32'hFFFF_FFBE, 2'b00, 2, 1, 0)); // LB lane1
        add(mk(1, 3'b001, 32'h16, 32'hAAAA_1234,  32'h0,         2'b00, 3, 1, 1)); // SH upper
        add(mk(0, 3'b010, 32'h14, 32'h0,          32'h1234_7788, 2'b00, 2, 1, 0)); // LW after SH
        add(mk(0, 3'b010, 32'h7C, 32'h0,          32'hCAFE_F00D, 2'b00, 2, 1, 0)); // last word
        add(mk(0, 3'b010, 32'h02, 32'h0,          32'h0,         2'b01, 1, 0, 0)); // LW misaligned
        add(mk(0, 3'b001, 32'h80, 32'h0,          32'h0,         2'b10, 1, 0, 0)); // LH range
        add(mk(1, 3'b011, 32'h81, 32'h5,          32'h0,         2'b11, 1, 0, 0)); // bad st f3
        add(mk(0, 3'b110, 32'h00, 32'h0,          32'h0,         2'b11, 1, 0, 0)); // bad ld f3
        add(mk(1, 3'b000, 32'h80, 32'h5,          32'h0,         2'b10, 1, 0, 0)); // SB range
        add(mk(1, 3'b001, 32'h05, 32'h5,          32'h0,         2'b01, 1, 0, 0)); // SH misaligned
        add(mk(0, 3'b001, 32'h81, 32'h0,          32'h0,         2'b01, 1, 0, 0)); // align > range

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_resp_rdata", resp_rdata, 32'h0);
        check("rst_resp_err", 32'(resp_err), 32'd0);
        check("rst_mem_strobes", {30'h0, mem_read, mem_write}, 32'h0);
        check("rst_mem_address", mem_address, 32'h0);
        check("rst_mem_wdata", mem_write_data, 32'h0);
        rst = 1'b0;

        for (int i = 0; i < nvec; i++) begin
            run_vec(vecs[i], i);
            if (i == 7) check("sb_word3", mem[3], 32'h8844_AABB);
            if (i == 9) check("sw_word4", mem[4], 32'hDEAD_BEEF);
            if (i == 13) check("sh_word5", mem[5], 32'h1234_7788);
        end

        // Reset during the WR cycle of an SH to word 1
        @(negedge clk);
        req_valid = 1'b1; req_is_store = 1'b1; req_funct3 = 3'b001;
        req_addr = 32'h04; req_wdata = 32'h0000_FFFF;
        @(posedge clk);                 // accepted, RD next
        @(negedge clk);
        req_valid = 1'b0;
        check("abort_rd", 32'(mem_read), 32'd1);
        @(posedge clk);                 // WR next
        @(negedge clk);
        check("abort_in_wr", 32'(mem_write), 32'd1);
        rst = 1'b1;
        #1;
        check("abort_wr_masked", 32'(mem_write), 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("abort_ready", 32'(req_ready), 32'd1);
        check("abort_no_resp", 32'(resp_valid), 32'd0);
        check("abort_word1", mem[1], 32'h7654_3210);
        @(negedge clk);
        check("abort_no_resp2", 32'(resp_valid), 32'd0);

        // Back-to-back: req_valid held high across two loads
        req_valid = 1'b1; req_is_store = 1'b0; req_funct3 = 3'b010;
        req_addr = 32'h00; req_wdata = 32'h0;
        e.rdata = 32'h0123_4567; e.err = 2'b00;
        exp_q.push_back(e);
        @(posedge clk);                 // first accepted
        @(negedge clk);
        req_addr = 32'h04;
        e.rdata = 32'h7654_3210;
        exp_q.push_back(e);
        edges = 1;
        while (!resp_valid && edges < 20) begin
            check("b2b_busy_ready", 32'(req_ready), 32'd0);
            @(posedge clk);
            edges++;
            @(negedge clk);
        end
        check("b2b_first_lat", 32'(edges), 32'd2);
        check("b2b_ready_in_resp", 32'(req_ready), 32'd0);
        @(posedge clk);
        @(negedge clk);
        check("b2b_ready_after_resp", 32'(req_ready), 32'd1);
        @(posedge clk);                 // second accepted
        @(negedge clk);
        req_valid = 1'b0;
        check("b2b_second_rd", 32'(mem_read), 32'd1);
        check("b2b_second_addr", mem_address, 32'h1);
        edges = 1;
        while (!resp_valid && edges < 20) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
        end
        check("b2b_second_lat", 32'(edges), 32'd2);

        repeat (2) @(negedge clk);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
